i2c_write_engine: RTL and testbench
===================================

Name: i2c_write_engine

Overview:
- Single-clock I2C master that performs one 3-byte write frame per request: START, slave address, sub-address, data, STOP.
- Directly downstream of the HDMI transmitter register-table sequencer. It accepts the sequencer's {slave, sub-addr, data} word with a level GO and returns END/ACK.
- Runs on the system clock with an internal bit-rate tick. No derived clock domain.
- Drives the shared I2C bus: SCL as a push-pull output, SDA as an open-drain line.

Parameters:
- CLK_Freq, 50000000: iCLK frequency in Hz.
- I2C_Freq, 20000: SCL frequency in Hz.
- TICK_DIV, CLK_Freq/(4*I2C_Freq): iCLK cycles per quarter-bit phase (625 at the defaults). Must be ≥2.

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  asynchronous active-low reset
- iDATA  in  24  [23:16] slave address incl. R/W bit, [15:8] sub-address, [7:0] data; sampled on GO acceptance
- iGO  in  1  level request; held high until oEND seen
- oEND  out  1  frame finished; held while iGO stays high
- oACK  out  1  0 = all bytes acknowledged, 1 = NACK received (frame aborted)
- oBUSY  out  1  high from GO acceptance until oEND rises
- I2C_SCLK  out  1  SCL, push-pull
- I2C_SDAT  inout  1  SDA; only ever drives 0, otherwise high-Z

Behaviour:
- Reset (async, iRST_N=0):
  - State IDLE; I2C_SCLK=1; SDA released (Z).
  - oEND=0, oACK=0, oBUSY=0; tick counter cleared.
  - Applies immediately, including mid-frame. The bus is released with no STOP generated.
- States: IDLE, START, BITS, STOP, DONE.
- Tick:
  - Counter runs 0..TICK_DIV-1 only outside IDLE; it is forced to 0 on GO acceptance.
  - One phase advance per wrap. Every slot (START, each bit, STOP) is 4 phases, ph0..ph3.
- IDLE:
  - If iGO=1, latch iDATA into a shift register, clear oACK, set oBUSY=1, and enter START ph0 on the next cycle.
  - If iGO=1 and oEND=1 (i.e. in DONE), no new acceptance occurs.
- START phases (SCL,SDA):
  - ph0: 1,1
  - ph1: 1,0
  - ph2: 1,0
  - ph3: 0,0
- BITS:
  - byte counter 0..2, bit counter 0..8. Bits 0..7 are the shifted data, MSB first. Bit 8 is ACK.
  - ph0: SCL=0, SDA set to the data bit (ACK slot: released).
  - ph1: SCL=1.
  - ph2: SCL=1; in the ACK slot, sample SDA (synchronised through a 2-FF path).
  - ph3: SCL=0.
- ACK result:
  - Sampled 0 (ACK): continue to the next byte, or to STOP after byte 2.
  - Sampled 1 (NACK): set oACK=1 and go to STOP; remaining bytes are skipped.
- STOP phases (SCL,SDA):
  - ph0: 0,0
  - ph1: 1,0
  - ph2: 1,1
  - ph3: 1,1
  - Then enter DONE.
- DONE:
  - oEND=1, oBUSY=0; bus idle (SCL=1, SDA=Z).
  - When iGO=0, clear oEND and return to IDLE on the next cycle.
- iGO dropping mid-frame is ignored; the frame always completes.
- iDATA changes after acceptance have no effect.
- Frame lengths (slots × 4 × TICK_DIV, counted from GO acceptance to oEND rising):
  - Full frame: 29 slots = 116×TICK_DIV iCLK cycles.
  - NACK on the address byte: 11 slots = 44×TICK_DIV.
  - NACK on the sub-address byte: 20 slots = 80×TICK_DIV.
- No clock stretching and no read support.
- SDA is never driven high. I2C_SDAT = drive_low ? 0 : Z.

Test Plan:
1. iDATA=24'h729803, iGO=1, slave model ACKs all bytes → START; serial bits 0111_0010 A 1001_1000 A 0000_0011 A; STOP. oEND rises after 116×625 cycles; oACK=0.
2. Slave NACKs the address byte → STOP follows immediately after the 9th bit. oEND after 44×625 cycles; oACK=1. No sub-address bits appear on SDA.
3. iGO held high for 10000 cycles after oEND → oEND stays 1 and no second START occurs. Drop iGO → oEND=0 the next cycle. Re-raise with 24'h720100 → a new frame carries 0x01 and 0x00.
4. Assert iRST_N=0 during bit 5 of the sub-address byte → same/next edge: SCL=1, SDA=Z, oEND=0, oACK=0, oBUSY=0. Release reset with iGO=1 → a clean full frame follows.
5. Instantiate with TICK_DIV=2 and check every phase: SDA changes only while SCL=0, except START (ph1 fall) and STOP (ph2 rise) with SCL=1. oBUSY=1 exactly from acceptance until oEND rises.

Source files
------------

// File: rtl/i2c_write_engine.sv
// Single-clock I2C master issuing one 3-byte write frame (slave, sub-address, data) per GO request.
// SCL is push-pull; SDA is open-drain and only ever pulled low.
module i2c_write_engine #(
  parameter int CLK_Freq = 50000000,
  parameter int I2C_Freq = 20000,
  parameter int TICK_DIV = CLK_Freq / (4 * I2C_Freq)
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [23:0] iDATA,
  input  logic        iGO,
  output logic        oEND,
  output logic        oACK,
  output logic        oBUSY,
  output logic        I2C_SCLK,
  inout  logic        I2C_SDAT
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, BITS, STOP, DONE} state_t;

  state_t        state, stateNxt;
  logic [TW-1:0] tick, tickNxt;
  logic [1:0]    phase, phaseNxt;
  logic [1:0]    byteCnt, byteNxt;
  logic [3:0]    bitCnt, bitNxt;
  logic [23:0]   shiftReg, shiftNxt;
  logic          nack, nackNxt;
  logic          ackR, ackNxt;
  logic          endR, endNxt;
  logic          busyR, busyNxt;
  logic          sclCur, sdaLowCur;
  logic          sclQ, sdaLowQ;
  logic          sdaMeta, sdaSync;
  logic          wrap, slotEnd;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      tick     <= '0;
      phase    <= '0;
      byteCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      nack     <= 1'b0;
      ackR     <= 1'b0;
      endR     <= 1'b0;
      busyR    <= 1'b0;
      sclQ     <= 1'b1;
      sdaLowQ  <= 1'b0;
      sdaMeta  <= 1'b1;
      sdaSync  <= 1'b1;
    end else begin
      state    <= stateNxt;
      tick     <= tickNxt;
      phase    <= phaseNxt;
      byteCnt  <= byteNxt;
      bitCnt   <= bitNxt;
      shiftReg <= shiftNxt;
      nack     <= nackNxt;
      ackR     <= ackNxt;
      endR     <= endNxt;
      busyR    <= busyNxt;
      sclQ     <= sclCur;
      sdaLowQ  <= sdaLowCur;
      sdaMeta  <= I2C_SDAT;
      sdaSync  <= sdaMeta;
    end
  end

  always_comb begin
    stateNxt  = state;
    tickNxt   = tick;
    phaseNxt  = phase;
    byteNxt   = byteCnt;
    bitNxt    = bitCnt;
    shiftNxt  = shiftReg;
    nackNxt   = nack;
    ackNxt    = ackR;
    endNxt    = endR;
    busyNxt   = busyR;
    sclCur    = 1'b1;
    sdaLowCur = 1'b0;
    wrap      = (tick == TICK_LAST);
    slotEnd   = wrap && (phase == 2'd3);

    if (state != IDLE) begin
      tickNxt = wrap ? '0 : tick + TW'(1);
      if (wrap) phaseNxt = phase + 2'd1;
    end

    case (state)
      IDLE: begin
        if (iGO) begin
          shiftNxt = iDATA;
          ackNxt   = 1'b0;
          busyNxt  = 1'b1;
          byteNxt  = '0;
          bitNxt   = '0;
          phaseNxt = '0;
          tickNxt  = '0;
          stateNxt = START;
        end
      end
      START: begin
        sclCur    = (phase != 2'd3);
        sdaLowCur = (phase != 2'd0);
        if (slotEnd) stateNxt = BITS;
      end
      BITS: begin
        sclCur    = (phase == 2'd1) || (phase == 2'd2);
        sdaLowCur = (bitCnt != 4'd8) && !shiftReg[23];
        if (wrap && (phase == 2'd2) && (bitCnt == 4'd8)) nackNxt = sdaSync;
        if (slotEnd) begin
          if (bitCnt == 4'd8) begin
            bitNxt = '0;
            if (nack) begin
              ackNxt   = 1'b1;
              stateNxt = STOP;
            end else if (byteCnt == 2'd2) begin
              stateNxt = STOP;
            end else begin
              byteNxt = byteCnt + 2'd1;
            end
          end else begin
            // the ACK slot does not shift, so the next byte's MSB is already at bit 23
            bitNxt   = bitCnt + 4'd1;
            shiftNxt = {shiftReg[22:0], 1'b0};
          end
        end
      end
      STOP: begin
        sclCur    = (phase != 2'd0);
        sdaLowCur = !phase[1];
        if (slotEnd) begin
          endNxt   = 1'b1;
          busyNxt  = 1'b0;
          stateNxt = DONE;
        end
      end
      DONE: begin
        if (!iGO) begin
          endNxt   = 1'b0;
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // bus pins come from registers so SCL/SDA cannot glitch on state decode
  assign I2C_SCLK = sclQ;
  assign I2C_SDAT = sdaLowQ ? 1'b0 : 1'bz;
  assign oEND     = endR;
  assign oACK     = ackR;
  assign oBUSY    = busyR;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: table-driven and random frames against a byte-level
// I2C slave/bus monitor and a frame-length model derived from slot counts.
module tb_i2c_write_engine;

  // small divider keeps every frame short; odd value exercises a non power-of-two wrap
  localparam int TD = 3;

  logic        iCLK   = 1'b0;
  logic        iRST_N = 1'b1;
  logic [23:0] iDATA  = '0;
  logic        iGO    = 1'b0;
  logic        oEND, oACK, oBUSY, I2C_SCLK;
  wire         I2C_SDAT;

  logic slaveLow = 1'b0;
  assign I2C_SDAT = slaveLow ? 1'b0 : 1'bz;
  pullup (I2C_SDAT);

  i2c_write_engine #(
    .CLK_Freq(50000000),
    .I2C_Freq(20000),
    .TICK_DIV(TD)
  ) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .iDATA   (iDATA),
    .iGO     (iGO),
    .oEND    (oEND),
    .oACK    (oACK),
    .oBUSY   (oBUSY),
    .I2C_SCLK(I2C_SCLK),
    .I2C_SDAT(I2C_SDAT)
  );

  always #5 iCLK = ~iCLK;

  int nCmp = 0;
  int nErr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- slave / bus monitor ----------------
  int         nackByte = 3;  // byte index the slave refuses; 3 = acknowledge all
  logic       slvClr = 1'b0;
  logic       sclPrev = 1'b1, sdaPrev = 1'b1;
  logic       inFrame = 1'b0;
  int         bitCount = 0, byteIdx = 0;
  int         startCnt = 0, stopCnt = 0, violCnt = 0;
  logic [7:0] shiftIn = '0;
  logic [7:0] rxQ[$];

  always @(negedge iCLK) begin
    logic sclNow, sdaNow;
    sclNow = I2C_SCLK;
    sdaNow = I2C_SDAT;
    if (slvClr) begin
      inFrame  = 1'b0;
      bitCount = 0;
      byteIdx  = 0;
      slaveLow = 1'b0;
    end else begin
      if (iRST_N && (sclNow != sclPrev) && (sdaNow != sdaPrev)) violCnt++;
      if (sclNow && sclPrev && sdaPrev && !sdaNow) begin
        startCnt++;
        inFrame  = 1'b1;
        bitCount = 0;
        byteIdx  = 0;
      end else if (sclNow && sclPrev && !sdaPrev && sdaNow) begin
        stopCnt++;
        inFrame  = 1'b0;
        slaveLow = 1'b0;
      end else if (inFrame && sclNow && !sclPrev) begin
        if (bitCount < 8) shiftIn = {shiftIn[6:0], sdaNow};
        bitCount++;
      end else if (inFrame && !sclNow && sclPrev) begin
        if (bitCount == 8) begin
          rxQ.push_back(shiftIn);
          slaveLow = (byteIdx != nackByte);
        end else if (bitCount == 9) begin
          slaveLow = 1'b0;
          bitCount = 0;
          byteIdx++;
        end
      end
    end
    sclPrev = sclNow;
    sdaPrev = sdaNow;
  end

  // ---------------- one frame, checked against the slot model ----------------
  task automatic runFrame(input logic [23:0] data, input int nb, input int hold,
                          input bit dropGo, input bit relRst,
                          input int expLat, input logic expAck);
    int s0, p0, v0, r0, cyc, busyErr, holdErr, nBytes;
    bit seen;
    logic [23:0] d;
    s0 = startCnt; p0 = stopCnt; v0 = violCnt; r0 = rxQ.size();
    d = data;
    nackByte = nb;
    @(negedge iCLK);
    iDATA = data;
    iGO   = 1'b1;
    if (relRst) iRST_N = 1'b1;
    @(posedge iCLK); #1;
    check("accept_busy_end_ack", {29'd0, oBUSY, oEND, oACK}, 32'b100);
    iDATA = 24'($urandom);
    cyc = 0; busyErr = 0; seen = 1'b0;
    while (!seen && cyc < 4000) begin
      @(posedge iCLK); #1;
      cyc++;
      if (oEND) seen = 1'b1;
      else if (!oBUSY) busyErr++;
      if (dropGo && cyc == expLat / 2) iGO = 1'b0;
    end
    check("end_seen", {31'd0, seen}, 32'd1);
    check("latency", cyc, expLat);
    check("busy_at_end", {31'd0, oBUSY}, 32'd0);
    check("busy_gap", busyErr, 0);
    check("ack_result", {31'd0, oACK}, {31'd0, expAck});
    if (hold > 0) begin
      holdErr = 0;
      for (int i = 0; i < hold; i++) begin
        @(posedge iCLK); #1;
        if (!oEND || oBUSY) holdErr++;
      end
      check("hold_end", holdErr, 0);
    end
    @(negedge iCLK);
    iGO = 1'b0;
    @(posedge iCLK); #1;
    check("end_clear", {31'd0, oEND}, 32'd0);
    repeat (2) @(negedge iCLK);
    nBytes = (nb < 3) ? nb + 1 : 3;
    check("rx_count", rxQ.size() - r0, nBytes);
    for (int i = 0; i < nBytes; i++)
      if (r0 + i < rxQ.size())
        check("rx_byte", {24'd0, rxQ[r0 + i]}, {24'd0, d[23 - 8 * i -: 8]});
    check("start_count", startCnt - s0, 1);
    check("stop_count", stopCnt - p0, 1);
    check("sda_scl_same_edge", violCnt - v0, 0);
  endtask

  typedef struct {
    logic [23:0] data;
    int          nb;
    int          hold;
    bit          drop;
    logic        expAck;
    int          expLat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int reached, nb, nBytes;
    logic [23:0] rd;

    tbl[0] = '{24'h729803, 3, 0,     1'b0, 1'b0, 116 * TD};
    tbl[1] = '{24'h72ABCD, 0, 0,     1'b0, 1'b1, 44 * TD};
    tbl[2] = '{24'h729803, 1, 0,     1'b1, 1'b1, 80 * TD};
    tbl[3] = '{24'h7255AA, 2, 0,     1'b0, 1'b1, 116 * TD};
    tbl[4] = '{24'h729803, 3, 10000, 1'b0, 1'b0, 116 * TD};
    tbl[5] = '{24'h720100, 3, 0,     1'b0, 1'b0, 116 * TD};

    #2 iRST_N = 1'b0;
    #1 check("reset_state", {27'd0, I2C_SCLK, I2C_SDAT, oEND, oACK, oBUSY}, 32'b11000);
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (4) @(posedge iCLK);
    #1 check("idle_no_go", {29'd0, oBUSY, oEND, I2C_SCLK}, 32'b001);

    for (int i = 0; i < 6; i++)
      runFrame(tbl[i].data, tbl[i].nb, tbl[i].hold, tbl[i].drop, 1'b0,
               tbl[i].expLat, tbl[i].expAck);

    // reset in the middle of the sub-address byte, then a clean frame
    nackByte = 3;
    @(negedge iCLK);
    iDATA = 24'h729803;
    iGO   = 1'b1;
    reached = 0;
    for (int c = 0; c < 2000 && reached == 0; c++) begin
      @(posedge iCLK);
      if (byteIdx == 1 && bitCount == 5) reached = 1;
    end
    check("reset_point_reached", reached, 1);
    @(negedge iCLK); #2;
    iRST_N = 1'b0;
    slvClr = 1'b1;
    #1 check("midframe_reset", {27'd0, I2C_SCLK, I2C_SDAT, oEND, oACK, oBUSY}, 32'b11000);
    repeat (3) @(negedge iCLK);
    slvClr = 1'b0;
    runFrame(24'h729803, 3, 0, 1'b0, 1'b1, 116 * TD, 1'b0);

    // random frames against the slot-count model
    for (int i = 0; i < 8; i++) begin
      rd     = 24'($urandom);
      nb     = int'($urandom_range(0, 3));
      nBytes = (nb < 3) ? nb + 1 : 3;
      runFrame(rd, nb, 0, 1'($urandom_range(0, 1)), 1'b0,
               (2 + 9 * nBytes) * 4 * TD, (nb < 3) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
